// File: rtl/miner_pkg.sv
//------------------------------------------------------------------------------
// Module  : miner_pkg
// Brief   : Shared constants and FSM state type for the miner job link.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package miner_pkg;

  localparam int HDR_BITS     = 608;  // header without nonce
  localparam int TGT_BITS     = 256;  // difficulty target
  localparam int RESULT_BYTES = 37;   // status + nonce + digest

  localparam logic [7:0] STATUS_FOUND   = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h00;

  typedef enum logic [2:0] {
    RX_HDR = 3'd0,
    RX_TGT = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    TX     = 3'd4
  } link_state_t;

endpackage

`default_nettype wire

// File: rtl/miner_job_link_if.sv
//------------------------------------------------------------------------------
// Module  : miner_job_link_if
// Brief   : Host-side byte streams (job in, result out) with valid/ready.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface miner_job_link_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // Link block side: consumes job bytes, produces result bytes.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  // Host side: produces job bytes, consumes result bytes.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/miner_result_tx.sv
//------------------------------------------------------------------------------
// Module  : miner_result_tx
// Brief   : Loads a result frame and streams it out MSB-first, one byte per
//           accepted valid/ready transfer; pulses done on the last byte.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module miner_result_tx
  import miner_pkg::*;
#(
  parameter int FRAME_BYTES = RESULT_BYTES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [8*FRAME_BYTES-1:0] frame,
  output logic [7:0]               data,
  output logic                     valid,
  input  logic                     ready,
  output logic                     done
);

  localparam int         FRAME_BITS = 8 * FRAME_BYTES;
  localparam logic [6:0] LAST_IDX   = 7'(FRAME_BYTES - 1);

  logic [FRAME_BITS-1:0] shift_q;
  logic [6:0]            idx_q;
  logic                  valid_q;
  logic                  fire;

  assign fire  = valid_q && ready;
  assign done  = fire && (idx_q == LAST_IDX);
  assign data  = shift_q[FRAME_BITS-1 -: 8];
  assign valid = valid_q;

  // Frame shifter: data only advances on an accepted byte, so it holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= frame;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      if (idx_q == LAST_IDX) begin
        shift_q <= '0;
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        shift_q <= {shift_q[FRAME_BITS-9:0], 8'h00};
        idx_q   <= idx_q + 7'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/miner_job_link.sv
//------------------------------------------------------------------------------
// Module  : miner_job_link
// Brief   : Host front end of the hashing core. Assembles a job (header then
//           target) from a byte stream, starts the core, waits for its finish
//           edge or a timeout, and returns a status/nonce/digest frame.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module miner_job_link
  import miner_pkg::*;
#(
  parameter int          HDR_BYTES  = HDR_BITS / 8,
  parameter int          TGT_BYTES  = TGT_BITS / 8,
  parameter logic [31:0] WAIT_LIMIT = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  miner_job_link_if.slave        host,
  output logic [8*HDR_BYTES-1:0] miner_header,
  output logic [8*TGT_BYTES-1:0] miner_target,
  output logic                   miner_start,
  input  logic [255:0]           miner_digest,
  input  logic [31:0]            miner_nonce,
  input  logic                   miner_finish,
  output logic                   busy
);

  localparam int          HB        = 8 * HDR_BYTES;
  localparam int          TB        = 8 * TGT_BYTES;
  localparam logic [6:0]  HDR_LAST  = 7'(HDR_BYTES - 1);
  localparam logic [6:0]  TGT_LAST  = 7'(TGT_BYTES - 1);
  localparam logic [31:0] WAIT_LAST = WAIT_LIMIT - 32'd1;

  link_state_t             state_q, state_d;
  logic [6:0]              idx_q;
  logic                    idx_last;
  logic                    in_ready_q;
  logic                    in_fire;
  logic                    start_q;
  logic                    finish_q;
  logic                    finish_evt;
  logic [31:0]             wait_q;
  logic [HB-1:0]           hdr_q;
  logic [TB-1:0]           tgt_q;
  logic                    tx_load;
  logic [8*RESULT_BYTES-1:0] tx_frame;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_done;

  assign in_fire    = host.in_valid && in_ready_q &&
                      ((state_q == RX_HDR) || (state_q == RX_TGT));
  // A finish level carried over from an earlier job is not an event.
  assign finish_evt = miner_finish && !finish_q;

  assign host.in_ready  = in_ready_q;
  assign host.out_data  = tx_data;
  assign host.out_valid = tx_valid;
  assign miner_header   = hdr_q;
  assign miner_target   = tgt_q;
  assign miner_start    = start_q;
  assign busy           = (state_q != RX_HDR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RX_HDR;
    else       state_q <= state_d;
  end

  // Next-state logic and result frame selection; event beats timeout in WAIT.
  always_comb begin
    state_d  = state_q;
    idx_last = 1'b0;
    tx_load  = 1'b0;
    tx_frame = '0;
    case (state_q)
      RX_HDR: begin
        idx_last = (idx_q == HDR_LAST);
        if (in_fire && idx_last) state_d = RX_TGT;
      end
      RX_TGT: begin
        idx_last = (idx_q == TGT_LAST);
        if (in_fire && idx_last) state_d = START;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (finish_evt) begin
          tx_load  = 1'b1;
          tx_frame = {STATUS_FOUND, miner_nonce, miner_digest};
          state_d  = TX;
        end else if (wait_q == WAIT_LAST) begin
          tx_load  = 1'b1;
          tx_frame = {STATUS_TIMEOUT, {(8*RESULT_BYTES-8){1'b0}}};
          state_d  = TX;
        end
      end
      TX: if (tx_done) state_d = RX_HDR;
      default: state_d = RX_HDR;
    endcase
  end

  // Registered handshake/start outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      in_ready_q <= (state_d == RX_HDR) || (state_d == RX_TGT);
      start_q    <= (state_d == START);
    end
  end

  // Byte index within the current section; wraps on the last index of each.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        idx_q <= '0;
    else if (in_fire) idx_q <= idx_last ? 7'd0 : idx_q + 7'd1;
  end

  // Job byte assembly: byte k lands at the k-th byte from the MSB end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q <= '0;
      tgt_q <= '0;
    end else if (in_fire) begin
      if (state_q == RX_HDR) hdr_q[HB-1-8*int'(idx_q) -: 8] <= host.in_data;
      else                   tgt_q[TB-1-8*int'(idx_q) -: 8] <= host.in_data;
    end
  end

  // Finish edge detector and cycles-in-WAIT counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      finish_q <= miner_finish;
      wait_q   <= (state_q == WAIT) ? wait_q + 32'd1 : 32'd0;
    end
  end

  miner_result_tx #(
    .FRAME_BYTES (RESULT_BYTES)
  ) u_result_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .frame (tx_frame),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (host.out_ready),
    .done  (tx_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_miner_job_link.sv
//------------------------------------------------------------------------------
// Module  : tb_miner_job_link
// Brief   : Self-checking bench for miner_job_link with a stub core and a
//           behavioural frame model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_miner_job_link;
  import miner_pkg::*;

  localparam int WL = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [607:0] miner_header;
  logic [255:0] miner_target;
  logic         miner_start;
  logic [255:0] miner_digest;
  logic [31:0]  miner_nonce;
  logic         miner_finish;
  logic         busy;

  miner_job_link_if host();

  miner_job_link #(
    .HDR_BYTES  (76),
    .TGT_BYTES  (32),
    .WAIT_LIMIT (32'd100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host         (host),
    .miner_header (miner_header),
    .miner_target (miner_target),
    .miner_start  (miner_start),
    .miner_digest (miner_digest),
    .miner_nonce  (miner_nonce),
    .miner_finish (miner_finish),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rdy_pct = 100;
  bit         mon_en = 1'b0;
  int         rx_idx = 0;
  int         start_cnt = 0;
  bit         stalled = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] exp_frame [37];
  logic [7:0] rx_log [37];
  logic [7:0] hdr_b [76];
  logic [7:0] tgt_b [32];

  localparam logic [255:0] DIG1 =
    {32'hd883d7a3, 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978, 32'h890f83da};

  task automatic chk(input string name, input logic [607:0] act, input logic [607:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [607:0] model_header();
    logic [607:0] h = '0;
    for (int k = 0; k < 76; k++) h = {h[599:0], hdr_b[k]};
    return h;
  endfunction

  function automatic logic [255:0] model_target();
    logic [255:0] t = '0;
    for (int k = 0; k < 32; k++) t = {t[247:0], tgt_b[k]};
    return t;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  task automatic fill_job1();
    logic [31:0] head0 = 32'h01000000;
    logic [31:0] head1 = 32'h81cd02ab;
    logic [31:0] tail  = 32'hf2b9441a;
    for (int k = 0; k < 76; k++) hdr_b[k] = 8'(k * 29 + 7);
    for (int k = 0; k < 4; k++) begin
      hdr_b[k]      = head0[31-8*k -: 8];
      hdr_b[4+k]    = head1[31-8*k -: 8];
      hdr_b[72+k]   = tail[31-8*k -: 8];
    end
    for (int k = 0; k < 32; k++) tgt_b[k] = 8'hff;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 76; k++) hdr_b[k] = 8'($urandom);
    for (int k = 0; k < 32; k++) tgt_b[k] = 8'($urandom);
  endtask

  // Host out_ready: re-rolled every cycle just after the active edge.
  always @(posedge clk) begin
    #1;
    host.out_ready = ($urandom_range(99) < rdy_pct);
  end

  // Compare process: every result transfer against the frame model, stall stability, start count.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (miner_start) start_cnt++;
      if (host.out_valid) begin
        if (stalled) begin
          checks++;
          if (host.out_data !== held) begin
            errors++;
            $display("FAIL stall_stable byte=%0d actual=%h required=%h", rx_idx, host.out_data, held);
          end
        end
        if (host.out_ready) begin
          checks++;
          if (rx_idx >= 37) begin
            errors++;
            $display("FAIL extra_byte actual=%h required=no transfer", host.out_data);
          end else begin
            rx_log[rx_idx] = host.out_data;
            if (host.out_data !== exp_frame[rx_idx]) begin
              errors++;
              $display("FAIL frame_byte%0d actual=%h required=%h", rx_idx, host.out_data, exp_frame[rx_idx]);
            end
            rx_idx++;
          end
        end
        stalled = !host.out_ready;
        held    = host.out_data;
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    int n = 0;
    int g = 0;
    while (g < 10 && $urandom_range(99) < gap) begin
      host.in_valid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    host.in_valid = 1'b1;
    host.in_data  = b;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = host.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    host.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("rst_in_ready", host.in_ready, 0);
    chk("rst_out_valid", host.out_valid, 0);
    chk("rst_start", miner_start, 0);
    chk("rst_header", miner_header, 0);
    chk("rst_target", miner_target, 0);
    chk("rst_busy", busy, 0);
    host.in_valid = 1'b0;
    miner_finish  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_release", host.in_ready, 1);
  endtask

  // One full job: stub core raises finish rise_n cycles after the START cycle (0 = never).
  task automatic run_job(input int gap, input int rdy, input bit pre_high, input int drop_n,
                         input int rise_n, input logic [31:0] nonce, input logic [255:0] dig,
                         input int rst_tgt_at, input int rst_tx_at);
    bit           found;
    logic [255:0] d;
    int           t;
    int           tx_at;
    int           want_tx;
    bit           bp_ok;
    int           n;
    found = (rise_n > 0) && (rise_n <= WL) && !(pre_high && drop_n == 0);
    exp_frame[0] = found ? 8'h01 : 8'h00;
    for (int i = 0; i < 4; i++) exp_frame[1+i] = found ? nonce[31-8*i -: 8] : 8'h00;
    d = dig;
    for (int i = 0; i < 32; i++) begin
      exp_frame[5+i] = found ? d[255:248] : 8'h00;
      d = d << 8;
    end
    rdy_pct      = rdy;
    miner_finish = pre_high;
    miner_nonce  = nonce;
    miner_digest = dig;
    rx_idx = 0;
    start_cnt = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 76; k++) send_byte(hdr_b[k], gap);
    for (int k = 0; k < 32; k++) begin
      if (k == rst_tgt_at) begin
        do_reset();
        return;
      end
      send_byte(tgt_b[k], gap);
    end
    chk("start_after_last_tgt", miner_start, 1);
    chk("header_loaded", miner_header, model_header());
    chk("target_loaded", miner_target, model_target());
    host.in_valid = 1'b1;
    host.in_data  = 8'hA5;
    t = 0;
    tx_at = -1;
    bp_ok = 1'b1;
    while (t < WL + 20 && tx_at < 0) begin
      @(posedge clk); #1;
      t++;
      if (pre_high && drop_n > 0 && t == drop_n) miner_finish = 1'b0;
      if (t == rise_n) miner_finish = 1'b1;
      if (host.in_ready) bp_ok = 1'b0;
      if (host.out_valid) tx_at = t;
    end
    host.in_valid = 1'b0;
    want_tx = found ? rise_n + 1 : WL + 1;
    chk("tx_start_cycle", 32'(tx_at), 32'(want_tx));
    chk("busy_backpressure", bp_ok, 1);
    n = 0;
    while (rx_idx < 37 && n < 3000) begin
      if (rst_tx_at >= 0 && rx_idx == rst_tx_at) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("frame_len", 32'(rx_idx), 32'd37);
    chk("valid_drop_after_last", host.out_valid, 0);
    chk("back_to_idle", busy, 0);
    chk("in_ready_idle", host.in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("no_extra_bytes", 32'(rx_idx), 32'd37);
    chk("single_start", 32'(start_cnt), 32'd1);
  endtask

  initial begin
    host.in_valid = 1'b0;
    host.in_data  = 8'h00;
    miner_finish  = 1'b0;
    miner_nonce   = '0;
    miner_digest  = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_in_ready", host.in_ready, 0);
    chk("reset_out_valid", host.out_valid, 0);
    chk("reset_start", miner_start, 0);
    chk("reset_header", miner_header, 0);
    chk("reset_target", miner_target, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_first_cycle", host.in_ready, 1);

    // Known job, no gaps; pin the model with literal expectations.
    fill_job1();
    run_job(0, 100, 1'b0, 0, 20, 32'h0, DIG1, -1, -1);
    chk("lit_header_top", miner_header[607:544], 64'h01000000_81cd02ab);
    chk("lit_header_tail", miner_header[31:0], 32'hf2b9441a);
    chk("lit_target", miner_target, {256{1'b1}});
    chk("lit_status", rx_log[0], 8'h01);
    chk("lit_nonce", {rx_log[1], rx_log[2], rx_log[3], rx_log[4]}, 32'h0);
    chk("lit_digest_first", {rx_log[5], rx_log[6]}, 16'hd883);
    chk("lit_digest_last", rx_log[36], 8'hda);

    // Same job with ~50% input gaps.
    run_job(50, 100, 1'b0, 0, 35, 32'h0, DIG1, -1, -1);

    // Random job, pseudo-random out_ready.
    fill_random();
    run_job(30, 50, 1'b0, 0, 17, $urandom, rand256(), -1, -1);

    // Core never finishes: timeout frame, core values must not leak.
    fill_random();
    run_job(0, 60, 1'b0, 0, 0, 32'hdeadbeef, rand256(), -1, -1);
    chk("lit_timeout_status", rx_log[0], 8'h00);

    // Finish rising in the last WAIT cycle wins; one cycle later is a timeout.
    run_job(0, 100, 1'b0, 0, WL, 32'h12345678, rand256(), -1, -1);
    chk("lit_boundary_status", rx_log[0], 8'h01);
    run_job(0, 100, 1'b0, 0, WL + 1, 32'h12345678, rand256(), -1, -1);

    // Finish held high from before: ignored until it drops and rises again.
    fill_random();
    run_job(0, 70, 1'b1, 0, 0, 32'hcafef00d, rand256(), -1, -1);
    run_job(0, 70, 1'b1, 3, 10, 32'hcafef00d, rand256(), -1, -1);

    // Reset mid target, then a clean job; reset mid frame, then a clean job.
    fill_random();
    run_job(0, 100, 1'b0, 0, 12, $urandom, rand256(), 10, -1);
    run_job(20, 80, 1'b0, 0, 12, $urandom, rand256(), -1, -1);
    run_job(0, 100, 1'b0, 0, 8, $urandom, rand256(), -1, 5);
    fill_random();
    run_job(0, 100, 1'b0, 0, 8, $urandom, rand256(), -1, -1);

    // A few fully random jobs.
    for (int j = 0; j < 3; j++) begin
      fill_random();
      run_job($urandom_range(60), $urandom_range(30, 100), 1'b0, 0,
              $urandom_range(1, 90), $urandom, rand256(), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
